// File: rtl/interposer_seg_arbiter_pkg.sv
// Shared constants, FSM state type and id-width helper for the interposer segment arbiter.
package interposer_pkg;

  localparam int DIR_LO_HI = 0;
  localparam int DIR_HI_LO = 1;

  localparam int SEND    = 2;
  localparam int RECEIVE = 1;
  localparam int BYPASS  = 0;

  typedef logic [0:0] state_t;
  localparam state_t ST_ARB  = 1'b0;
  localparam state_t ST_XFER = 1'b1;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/interposer_seg_alloc.sv
// Combinational round-robin greedy allocator: builds each request's link mask and picks the grant set.
// Optional INTERPOSER_SPATIAL_REUSE_EN allows several grants on disjoint link ranges.
module interposer_seg_alloc
  import interposer_pkg::*;
#(
  parameter int NODE_COUNT       = 8,
  parameter int NODE_COUNT_DIGIT = 3,
  parameter int RR_W             = 3,
  parameter int DIR              = 0
) (
  input  logic [NODE_COUNT-1:0]                  req_valid,
  input  logic [NODE_COUNT*NODE_COUNT_DIGIT-1:0] req_dest,
  input  logic [RR_W-1:0]                        rr_ptr,
  output logic [NODE_COUNT-1:0]                  grant,
  output logic [NODE_COUNT-1:0]                  illegal,
  output logic [RR_W-1:0]                        next_rr
);

  // Link j joins node j and node j+1.
  localparam int LINKS = NODE_COUNT - 1;

  logic [LINKS-1:0] taken;
  logic [LINKS-1:0] seg;
  logic             any;
  logic             legal;
  int               node;
  int               dest;
  int               lo;
  int               hi;

  always_comb begin
    grant   = '0;
    illegal = '0;
    taken   = '0;
    seg     = '0;
    any     = 1'b0;
    legal   = 1'b0;
    next_rr = rr_ptr;
    node    = 0;
    dest    = 0;
    lo      = 0;
    hi      = 0;
    for (int k = 0; k < NODE_COUNT; k++) begin
      node = int'(rr_ptr) + k;
      if (node >= NODE_COUNT) node = node - NODE_COUNT;
      dest  = int'(req_dest[node*NODE_COUNT_DIGIT +: NODE_COUNT_DIGIT]);
      legal = (dest != node) && (dest < NODE_COUNT) &&
              ((DIR == DIR_HI_LO) ? (dest < node) : (dest > node));
      lo = (dest < node) ? dest : node;
      hi = (dest < node) ? node : dest;
      for (int j = 0; j < LINKS; j++) seg[j] = (j >= lo) && (j < hi);
      if (req_valid[node]) begin
        if (!legal) begin
          illegal[node] = 1'b1;
        end
`ifdef INTERPOSER_SPATIAL_REUSE_EN
        else if ((seg & taken) == '0) begin
`else
        else if (!any) begin
`endif
          grant[node] = 1'b1;
          taken       = taken | seg;
          if (!any) next_rr = RR_W'((node + 1) % NODE_COUNT);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/interposer_seg_arbiter.sv
// Segment-chain arbiter top: ARB/XFER FSM, round-robin pointer, per-source beat counters, node controls.
// Build macro: INTERPOSER_SPATIAL_REUSE_EN (concurrent grants on disjoint link ranges).
module interposer_seg_arbiter
  import interposer_pkg::*;
#(
  parameter int NODE_COUNT       = 8,
  parameter int NODE_COUNT_DIGIT = 3,
  parameter int LEN_W            = 4,
  parameter int DIR              = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NODE_COUNT-1:0]                 req_valid,
  input  logic [NODE_COUNT*NODE_COUNT_DIGIT-1:0] req_dest,
  input  logic [NODE_COUNT*LEN_W-1:0]           req_len,
  output logic [NODE_COUNT-1:0]                 grant,
  output logic [NODE_COUNT-1:0]                 ctrl_send,
  output logic [NODE_COUNT-1:0]                 ctrl_receive,
  output logic [NODE_COUNT-1:0]                 ctrl_bypass,
  output logic [NODE_COUNT-1:0]                 err_dir,
  output logic                                  busy
);

  localparam int RR_W = id_width(NODE_COUNT);

  // Handshake: a requester holds req_valid/dest/len stable until its grant pulse, which is the
  // only acceptance indication; requests are sampled only in ARB and ignored during XFER.
  state_t                      state;
  logic [RR_W-1:0]             rr_ptr;
  logic [RR_W-1:0]             next_rr;
  logic [NODE_COUNT-1:0]       pick;
  logic [NODE_COUNT-1:0]       illegal;
  logic [NODE_COUNT-1:0]       err_seen;
  logic [LEN_W-1:0]            cnt [NODE_COUNT];
  logic [NODE_COUNT_DIGIT-1:0] act_dest [NODE_COUNT];
  logic [2:0]                  node_ctrl [NODE_COUNT];
  logic                        last_beat;
  int                          seg_dest;

  interposer_seg_alloc #(
    .NODE_COUNT       (NODE_COUNT),
    .NODE_COUNT_DIGIT (NODE_COUNT_DIGIT),
    .RR_W             (RR_W),
    .DIR              (DIR)
  ) u_alloc (
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .rr_ptr    (rr_ptr),
    .grant     (pick),
    .illegal   (illegal),
    .next_rr   (next_rr)
  );

  always_comb begin
    last_beat = 1'b1;
    for (int i = 0; i < NODE_COUNT; i++) begin
      if (cnt[i] > LEN_W'(1)) last_beat = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_ARB;
      rr_ptr   <= '0;
      grant    <= '0;
      err_dir  <= '0;
      err_seen <= '0;
      for (int i = 0; i < NODE_COUNT; i++) begin
        cnt[i]      <= '0;
        act_dest[i] <= '0;
      end
    end else begin
      grant    <= '0;
      err_dir  <= '0;
      err_seen <= err_seen & req_valid;
      if (state == ST_ARB) begin
        grant    <= pick;
        // An illegal request reports once and stays silent until it is withdrawn.
        err_dir  <= illegal & ~err_seen;
        err_seen <= (err_seen | illegal) & req_valid;
        rr_ptr   <= next_rr;
        for (int i = 0; i < NODE_COUNT; i++) begin
          if (pick[i]) begin
            cnt[i]      <= (req_len[i*LEN_W +: LEN_W] == '0) ? LEN_W'(1) : req_len[i*LEN_W +: LEN_W];
            act_dest[i] <= req_dest[i*NODE_COUNT_DIGIT +: NODE_COUNT_DIGIT];
          end
        end
        if (pick != '0) state <= ST_XFER;
      end else begin
        for (int i = 0; i < NODE_COUNT; i++) begin
          if (cnt[i] != '0) cnt[i] <= cnt[i] - LEN_W'(1);
        end
        if (last_beat) state <= ST_ARB;
      end
    end
  end

  // Controls of a transfer stay up while its own counter is nonzero, so short transfers drop early.
  always_comb begin
    seg_dest = 0;
    for (int n = 0; n < NODE_COUNT; n++) node_ctrl[n] = '0;
    for (int s = 0; s < NODE_COUNT; s++) begin
      if (cnt[s] != '0) begin
        seg_dest = int'(act_dest[s]);
        for (int n = 0; n < NODE_COUNT; n++) begin
          if (n == s) node_ctrl[n][SEND] = 1'b1;
          else if (n == seg_dest) node_ctrl[n][RECEIVE] = 1'b1;
          else if ((n > s && n < seg_dest) || (n < s && n > seg_dest)) node_ctrl[n][BYPASS] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NODE_COUNT; n++) begin
      ctrl_send[n]    = node_ctrl[n][SEND];
      ctrl_receive[n] = node_ctrl[n][RECEIVE];
      ctrl_bypass[n]  = node_ctrl[n][BYPASS];
    end
  end

  assign busy = (state == ST_XFER);

endmodule
